// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a five-stage pipeline. Shadow copies of the
// result-carrying stages after D track which register each in-flight
// instruction writes and how many cycles remain until its value exists.
// From these the block derives D-stage stalls, D/E forwarding selects and
// a busy/stall interlock for the iterative multiply/divide unit.
module hazard_scoreboard #(
    parameter int NSTAGE  = 3,
    parameter int TW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    localparam int FW     = $clog2(NSTAGE + 1),
    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT,
    localparam int CW     = $clog2(MAXLAT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic          d_rs_used,
    input  logic          d_rt_used,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic          d_wr,
    input  logic [4:0]    d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_access,
    output logic          stall,
    output logic          en_pc,
    output logic          en_fd,
    output logic          clr_de,
    output logic          md_busy,
    output logic [FW-1:0] fwd_d_rs,
    output logic [FW-1:0] fwd_d_rt,
    output logic [FW-1:0] fwd_e_rs,
    output logic [FW-1:0] fwd_e_rt
);

    logic [NSTAGE:1] valid_q;
    logic [NSTAGE:1] wr_q;
    logic [4:0]      a3_q   [1:NSTAGE];
    logic [TW-1:0]   tnew_q [1:NSTAGE];
    logic [4:0]      e_rs_q, e_rt_q;
    logic            e_rs_used_q, e_rt_used_q;
    logic [CW-1:0]   md_cnt_q, md_cnt_d;

    logic            rs_found, rt_found;
    logic [FW-1:0]   rs_idx, rt_idx;
    logic [TW-1:0]   rs_tnew, rt_tnew;
    logic            op_stall, md_stall;

    // D-operand producer search; scanning from the far end lets the nearest match win
    always_comb begin
        rs_found = 1'b0;
        rt_found = 1'b0;
        rs_idx   = '0;
        rt_idx   = '0;
        rs_tnew  = '0;
        rt_tnew  = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (valid_q[k] && wr_q[k] && a3_q[k] == d_rs && d_rs != 5'd0) begin
                rs_found = 1'b1;
                rs_idx   = FW'(k);
                rs_tnew  = tnew_q[k];
            end
            if (valid_q[k] && wr_q[k] && a3_q[k] == d_rt && d_rt != 5'd0) begin
                rt_found = 1'b1;
                rt_idx   = FW'(k);
                rt_tnew  = tnew_q[k];
            end
        end
    end

    // E-operand forwarding: producers for the instruction now in stage 1 live in stages 2..NSTAGE
    always_comb begin
        fwd_e_rs = '0;
        fwd_e_rt = '0;
        for (int k = NSTAGE; k >= 2; k--) begin
            if (valid_q[k] && wr_q[k] && a3_q[k] == e_rs_q) begin
                fwd_e_rs = (tnew_q[k] == '0) ? FW'(k) : '0;
            end
            if (valid_q[k] && wr_q[k] && a3_q[k] == e_rt_q) begin
                fwd_e_rt = (tnew_q[k] == '0) ? FW'(k) : '0;
            end
        end
        if (!e_rs_used_q || e_rs_q == 5'd0) fwd_e_rs = '0;
        if (!e_rt_used_q || e_rt_q == 5'd0) fwd_e_rt = '0;
    end

    // Stall, pipeline enables and D-stage forwarding selects
    always_comb begin
        op_stall = (d_rs_used && rs_found && rs_tnew > d_rs_tuse) ||
                   (d_rt_used && rt_found && rt_tnew > d_rt_tuse);
        md_stall = (d_md_start || d_md_access) && md_busy;
        stall    = op_stall || md_stall;
        en_pc    = ~stall;
        en_fd    = ~stall;
        clr_de   = stall;
        fwd_d_rs = (rs_found && rs_tnew == '0) ? rs_idx : '0;
        fwd_d_rt = (rt_found && rt_tnew == '0) ? rt_idx : '0;
    end

    // Multiply/divide countdown; a start blocked by a stall does not reload
    always_comb begin
        md_busy  = (md_cnt_q != '0);
        md_cnt_d = md_cnt_q;
        if (d_md_start && !stall) begin
            md_cnt_d = d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    // Shadow pipeline advance; a stalled D inserts a bubble into stage 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            wr_q        <= '0;
            e_rs_q      <= '0;
            e_rt_q      <= '0;
            e_rs_used_q <= 1'b0;
            e_rt_used_q <= 1'b0;
            md_cnt_q    <= '0;
            for (int k = 1; k <= NSTAGE; k++) begin
                a3_q[k]   <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            md_cnt_q <= md_cnt_d;
            for (int k = 2; k <= NSTAGE; k++) begin
                valid_q[k] <= valid_q[k-1];
                wr_q[k]    <= wr_q[k-1];
                a3_q[k]    <= a3_q[k-1];
                tnew_q[k]  <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
            end
            if (!stall) begin
                valid_q[1]  <= 1'b1;
                wr_q[1]     <= d_wr;
                a3_q[1]     <= d_a3;
                tnew_q[1]   <= d_tnew;
                e_rs_q      <= d_rs;
                e_rt_q      <= d_rt;
                e_rs_used_q <= d_rs_used;
                e_rt_used_q <= d_rt_used;
            end else begin
                valid_q[1]  <= 1'b0;
                wr_q[1]     <= 1'b0;
                a3_q[1]     <= '0;
                tnew_q[1]   <= '0;
                e_rs_q      <= '0;
                e_rt_q      <= '0;
                e_rs_used_q <= 1'b0;
                e_rt_used_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk, reset;
    logic [4:0] d_rs, d_rt, d_a3;
    logic       d_rs_used, d_rt_used, d_wr;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_md_start, d_md_div, d_md_access;
    logic       stall, en_pc, en_fd, clr_de, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_wr(d_wr), .d_a3(d_a3), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_access(d_md_access),
        .stall(stall), .en_pc(en_pc), .en_fd(en_fd), .clr_de(clr_de), .md_busy(md_busy),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;  logic ru; logic [1:0] rtu;
        logic [4:0] rt;  logic tu; logic [1:0] ttu;
        logic       wr;  logic [4:0] a3; logic [1:0] tnew;
        logic       e_stall;
        logic [1:0] e_fdrs, e_fdrt, e_fers, e_fert;
    } vec_t;

    vec_t vec [15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic ru, input logic [1:0] rtu,
                         input logic [4:0] rt, input logic tu, input logic [1:0] ttu,
                         input logic wr, input logic [4:0] a3, input logic [1:0] tnew,
                         input logic mds, input logic mdd, input logic mda);
        d_rs = rs; d_rs_used = ru; d_rs_tuse = rtu;
        d_rt = rt; d_rt_used = tu; d_rt_tuse = ttu;
        d_wr = wr; d_a3 = a3; d_tnew = tnew;
        d_md_start = mds; d_md_div = mdd; d_md_access = mda;
    endtask

    task automatic check_all(input string tag, input int e_stall, input int e_busy,
                             input int fdrs, input int fdrt, input int fers, input int fert);
        check({tag, ".stall"},    stall,    e_stall);
        check({tag, ".clr_de"},   clr_de,   e_stall);
        check({tag, ".en_pc"},    en_pc,    1 - e_stall);
        check({tag, ".en_fd"},    en_fd,    1 - e_stall);
        check({tag, ".md_busy"},  md_busy,  e_busy);
        check({tag, ".fwd_d_rs"}, fwd_d_rs, fdrs);
        check({tag, ".fwd_d_rt"}, fwd_d_rt, fdrt);
        check({tag, ".fwd_e_rs"}, fwd_e_rs, fers);
        check({tag, ".fwd_e_rt"}, fwd_e_rt, fert);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        //            rs ru tu  rt tu ttu wr a3 tn  stall fdrs fdrt fers fert
        vec[0]  = '{0, 0, 0,  0, 0, 0,  1, 1, 2,  0, 0, 0, 0, 0}; // lw $1
        vec[1]  = '{1, 1, 1,  3, 1, 1,  1, 4, 1,  1, 0, 0, 0, 0}; // add uses $1: stall
        vec[2]  = '{1, 1, 1,  3, 1, 1,  1, 4, 1,  0, 0, 0, 0, 0}; // add retried
        vec[3]  = '{0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 3, 0}; // add in E, lw in W
        vec[4]  = '{0, 0, 0,  0, 0, 0,  1, 2, 1,  0, 0, 0, 0, 0}; // addu $2
        vec[5]  = '{2, 1, 0,  4, 1, 0,  0, 0, 0,  1, 0, 3, 0, 0}; // beq $2,$4: stall
        vec[6]  = '{2, 1, 0,  4, 1, 0,  0, 0, 0,  0, 2, 0, 0, 0}; // beq retried
        vec[7]  = '{0, 0, 0,  0, 0, 0,  1, 0, 2,  0, 0, 0, 3, 0}; // write $0
        vec[8]  = '{0, 1, 0,  0, 1, 0,  1, 5, 0,  0, 0, 0, 0, 0}; // read $0, write $5
        vec[9]  = '{0, 0, 0,  0, 0, 0,  1, 5, 0,  0, 0, 0, 0, 0}; // write $5
        vec[10] = '{5, 1, 1,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0}; // read $5
        vec[11] = '{0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 2, 0}; // nearest of stages 2/3
        vec[12] = '{0, 0, 0,  0, 0, 0,  1, 5, 0,  0, 0, 0, 0, 0}; // write $5 ready
        vec[13] = '{0, 0, 0,  0, 0, 0,  1, 5, 2,  0, 0, 0, 0, 0}; // write $5 late
        vec[14] = '{5, 1, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0}; // nearer late one wins

        drive(0,0,0, 0,0,0, 0,0,0, 0,0,0);
        reset = 1'b0;
        #2;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 15; i++) begin
            drive(vec[i].rs, vec[i].ru, vec[i].rtu, vec[i].rt, vec[i].tu, vec[i].ttu,
                  vec[i].wr, vec[i].a3, vec[i].tnew, 0, 0, 0);
            #3;
            check_all($sformatf("vec%0d", i), vec[i].e_stall, 0,
                      vec[i].e_fdrs, vec[i].e_fdrt, vec[i].e_fers, vec[i].e_fert);
            next_cycle();
        end

        // drain the shadow pipeline
        drive(0,0,0, 0,0,0, 0,0,0, 0,0,0);
        repeat (4) next_cycle();

        // multiply then mfhi: five busy stall cycles; then divide: ten
        for (int op = 0; op < 2; op++) begin
            drive(0,0,0, 0,0,0, 0,0,0, 1, op[0], 0);
            #3;
            check($sformatf("md%0d.issue_stall", op), stall, 0);
            check($sformatf("md%0d.issue_busy", op), md_busy, 0);
            next_cycle();
            drive(0,0,0, 0,0,0, 1,3,0, 0,0,1);
            cnt = 0;
            for (int c = 0; c < 20; c++) begin
                #3;
                if (!stall) break;
                cnt++;
                check($sformatf("md%0d.busy_during_stall", op), md_busy, 1);
                next_cycle();
            end
            check($sformatf("md%0d.stall_cycles", op), cnt, op ? 10 : 5);
            check($sformatf("md%0d.busy_after", op), md_busy, 0);
            next_cycle();
        end

        // reset in the middle of a divide
        drive(0,0,0, 0,0,0, 1,7,2, 1,1,0);
        next_cycle();
        drive(0,0,0, 0,0,0, 0,0,0, 0,0,1);
        #3;
        check("rst.stall_c1", stall, 1);
        next_cycle();
        #3;
        check("rst.stall_c2", stall, 1);
        next_cycle();
        #1;
        reset = 1'b0;
        #1;
        check("rst.md_busy_async", md_busy, 0);
        check("rst.stall_async", stall, 0);
        next_cycle();
        reset = 1'b1;
        drive(7,1,0, 7,1,0, 0,0,0, 0,0,0);
        #2;
        check_all("rst.after", 0, 0, 0, 0, 0, 0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
